// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide engine: 32 shift-add or restoring-division
// steps behind a start/ready handshake, with one-cycle resolution of special cases.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam int unsigned CNT_W = 6;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q;
  logic [2:0]         op_q;
  logic [XLEN-1:0]    a_q, b_q;
  logic [XLEN-1:0]    mag_a_q, mag_b_q;
  logic               neg_a_q, neg_b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    result_q;
  logic               ready_q, busy_q, done_q;

  logic               a_sgn_c, b_sgn_c, neg_a_c, neg_b_c;
  logic [XLEN-1:0]    mag_a_c, mag_b_c;
  logic [XLEN:0]      mul_sum_c;
  logic [ACC_W-1:0]   mul_next_c;
  logic [XLEN:0]      rem_sh_c;
  logic               div_keep_c;
  logic [ACC_W-1:0]   div_next_c;
  logic [ACC_W-1:0]   prod_c;
  logic [XLEN-1:0]    quot_c, rem_c, fix_res_c;
  logic               spec_c;
  logic [XLEN-1:0]    spec_res_c;

  // Operand signedness and magnitudes, evaluated from the latched request in SETUP
  always_comb begin
    a_sgn_c = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
              (op_q == OP_DIV) || (op_q == OP_REM);
    b_sgn_c = (op_q == OP_MUL) || (op_q == OP_MULH) ||
              (op_q == OP_DIV) || (op_q == OP_REM);
    neg_a_c = a_sgn_c && a_q[XLEN-1];
    neg_b_c = b_sgn_c && b_q[XLEN-1];
    mag_a_c = neg_a_c ? (~a_q + XLEN'(1)) : a_q;
    mag_b_c = neg_b_c ? (~b_q + XLEN'(1)) : b_q;
  end

  // One iteration step: multiply keeps {product_hi, multiplier}, divide keeps {remainder, quotient}
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[ACC_W-1:XLEN]} +
                 (acc_q[0] ? {1'b0, mag_a_q} : (XLEN+1)'(0));
    mul_next_c = {mul_sum_c, acc_q[XLEN-1:1]};
    rem_sh_c   = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    div_keep_c = (rem_sh_c >= {1'b0, mag_b_q});
    div_next_c = {(div_keep_c ? (rem_sh_c[XLEN-1:0] - mag_b_q) : rem_sh_c[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_keep_c};
  end

  // Sign correction and result selection
  always_comb begin
    prod_c = (neg_a_q ^ neg_b_q) ? (~acc_q + ACC_W'(1)) : acc_q;
    quot_c = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem_c  = neg_a_q ? (~acc_q[ACC_W-1:XLEN] + XLEN'(1)) : acc_q[ACC_W-1:XLEN];
    case (op_q)
      OP_MUL:                       fix_res_c = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_c[ACC_W-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res_c = quot_c;
      default:                      fix_res_c = rem_c;
    endcase
  end

  // Requests that resolve without iterating
  always_comb begin
    spec_c     = 1'b0;
    spec_res_c = '0;
    if (op_i[2]) begin
      if (b_i == '0) begin
        spec_c     = 1'b1;
        spec_res_c = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : a_i;
      end else if (((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (a_i == 32'h8000_0000) && (b_i == '1)) begin
        spec_c     = 1'b1;
        spec_res_c = (op_i == OP_DIV) ? 32'h8000_0000 : '0;
      end
    end else if ((a_i == '0) || (b_i == '0)) begin
      spec_c     = 1'b1;
      spec_res_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= S_IDLE;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              op_q <= op_i;
              a_q  <= a_i;
              b_q  <= b_i;
              if (spec_c) begin
                result_q <= spec_res_c;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
                ready_q  <= 1'b1;
                busy_q   <= 1'b0;
              end else begin
                state_q <= S_SETUP;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          S_SETUP: begin
            mag_a_q <= mag_a_c;
            mag_b_q <= mag_b_c;
            neg_a_q <= neg_a_c;
            neg_b_q <= neg_b_c;
            acc_q   <= {XLEN'(0), (op_q[2] ? mag_a_c : mag_b_c)};
            cnt_q   <= '0;
            state_q <= S_ITER;
          end
          S_ITER: begin
            acc_q <= op_q[2] ? div_next_c : mul_next_c;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
              state_q <= S_FIX;
            end
          end
          S_FIX: begin
            result_q <= fix_res_c;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus hand-written control sequences.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        ready, busy, done;
  logic [31:0] result;

  muldiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .ready_o  (ready),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives the request for one cycle, returns in the done cycle
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt, output logic [31:0] res);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    lat = -1; bcnt = 0; res = 32'h0;
    for (int i = 0; i < 100; i++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bcnt, nd;
    logic [31:0] res;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[3]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0};
    vecs[7]  = '{3'd7, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 1'b0};
    vecs[8]  = '{3'd5, 32'd123,       32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'd0, 32'd0,         32'd123,       32'h0000_0000, 1'b1};
    vecs[13] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[14] = '{3'd0, 32'd1000,      32'd1000,      32'h000F_4240, 1'b0};
    vecs[15] = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[16] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[17] = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'd0, ready}, 32'd1);
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_done",   {31'd0, done},  32'd0);
    chk("rst_result", result,         32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, res);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].spec ? 32'd0 : 32'd34);
      chk($sformatf("v%0d_busy", i), 32'(bcnt), vecs[i].spec ? 32'd0 : 32'd34);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Back-to-back: start in the DONE cycle, then a special case in the next DONE cycle
    do_op(3'd5, 32'd100, 32'd7, lat, bcnt, res);
    chk("b2b_first", res, 32'd14);
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, lat, bcnt, res);
    chk("b2b_second", res, 32'hFFFF_FFEB);
    chk("b2b_second_latency", 32'(lat), 32'd34);
    do_op(3'd5, 32'd9, 32'd0, lat, bcnt, res);
    chk("b2b_special", res, 32'hFFFF_FFFF);
    chk("b2b_special_latency", 32'(lat), 32'd0);

    // Flush together with start in a done cycle: flush wins, result held
    flush = 1'b1; start = 1'b1; op = 3'd6; a = 32'd5; b = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_done_done",   {31'd0, done},  32'd0);
    chk("flush_done_ready",  {31'd0, ready}, 32'd1);
    chk("flush_done_result", result,         32'hFFFF_FFFF);

    // Flush at ITER step 10
    op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("flush_iter_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_iter_busy",   {31'd0, busy},  32'd0);
    chk("flush_iter_ready",  {31'd0, ready}, 32'd1);
    chk("flush_iter_done",   {31'd0, done},  32'd0);
    chk("flush_iter_result", result,         32'hFFFF_FFFF);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("flush_iter_no_done", 32'(nd), 32'd0);
    do_op(3'd5, 32'd100, 32'd7, lat, bcnt, res);
    chk("after_flush_result", res, 32'd14);
    chk("after_flush_latency", 32'(lat), 32'd34);
    @(negedge clk);

    // Start pulsed while busy is ignored
    op = 3'd4; a = 32'd7; b = 32'hFFFF_FFFE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; res = 32'h0;
    for (int i = 0; i < 100; i++) begin
      start = (i == 5);
      op = (i == 5) ? 3'd0 : 3'd4;
      a  = (i == 5) ? 32'd0 : 32'd7;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_start_result", res, 32'hFFFF_FFFD);
    chk("busy_start_latency", 32'(lat), 32'd34);
    @(negedge clk);

    // Asynchronous reset mid-ITER
    op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready",  {31'd0, ready}, 32'd1);
    chk("midrst_busy",   {31'd0, busy},  32'd0);
    chk("midrst_done",   {31'd0, done},  32'd0);
    chk("midrst_result", result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
